// File: rtl/pit_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// pit_mem_arbiter_if
//
// Bundles the two requester handshakes (interest-in writer, data-out reader)
// and the single-port PIT packet memory bus into one interface.
//
// Signals:
//   wr_req / wr_addr / wr_len / wr_data  writer burst request, base, length, byte
//   wr_grant / wr_done                   writer ownership and end-of-burst pulse
//   rd_req / rd_addr / rd_len            reader burst request, base, length
//   rd_grant / rd_data / rd_valid / rd_done  reader ownership, byte, strobe, end pulse
//   mem_addr / mem_we / mem_wdata        memory command (driven by the arbiter)
//   mem_rdata                            memory read data, one cycle after mem_addr
//
// Modports:
//   slave  : the arbiter's view (serves requests, drives the memory bus)
//   master : the requesters' and memory's view
// ----------------------------------------------------------------------------
interface pit_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);

  // Writer side
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] wr_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_grant;
  logic              wr_done;

  // Reader side
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_len;
  logic              rd_grant;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_done;

  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_len, wr_data,
    input  rd_req, rd_addr, rd_len,
    input  mem_rdata,
    output wr_grant, wr_done,
    output rd_grant, rd_data, rd_valid, rd_done,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_len, wr_data,
    output rd_req, rd_addr, rd_len,
    output mem_rdata,
    input  wr_grant, wr_done,
    input  rd_grant, rd_data, rd_valid, rd_done,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/pit_mem_arbiter.sv
// ----------------------------------------------------------------------------
// pit_mem_arbiter
//
// Arbiter and burst sequencer for the single-port PIT packet memory.
// Two requesters share the memory: the writer stores a packet into its PIT
// slot, the reader streams a stored packet back out. Bursts never interleave;
// when both request at once, the one not served most recently wins.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset (aborts any burst, no done pulse)
//   bus    pit_mem_arbiter_if.slave: requester handshakes and memory bus
//
// All outputs are registered except rd_data, which is a straight copy of
// mem_rdata (the memory already delays read data by one cycle, which lines it
// up with rd_valid).
// ----------------------------------------------------------------------------

// Protocol checker: properties that must hold on the arbiter's outputs.
module pit_mem_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic wr_grant,
  input logic wr_done,
  input logic rd_grant,
  input logic rd_valid,
  input logic rd_done,
  input logic mem_we
);

  // Only one requester may own the memory at a time.
  a_grant_excl: assert property (@(posedge clk) disable iff (reset)
    !(wr_grant && rd_grant));

  // Writes never overlap with a read burst in flight.
  a_we_vs_read: assert property (@(posedge clk) disable iff (reset)
    !(mem_we && (rd_grant || rd_valid)));

  // Done strobes are single-cycle pulses.
  a_wr_done_pulse: assert property (@(posedge clk) disable iff (reset)
    wr_done |=> !wr_done);

  a_rd_done_pulse: assert property (@(posedge clk) disable iff (reset)
    rd_done |=> !rd_done);

endmodule

module pit_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  pit_mem_arbiter_if.slave      bus
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_W_TAIL = 3'd2,
    ST_READ   = 3'd3,
    ST_R_TAIL = 3'd4
  } state_e;

  // Which requester was served most recently (fairness pointer).
  typedef enum logic {
    LAST_WR = 1'b0,
    LAST_RD = 1'b1
  } last_e;

  // State and burst bookkeeping
  state_e            state_r,  state_s;
  last_e             last_r,   last_s;
  logic [ADDR_W-1:0] base_r,   base_s;
  logic [ADDR_W-1:0] len_r,    len_s;
  logic [ADDR_W-1:0] offset_r, offset_s;

  // Registered outputs
  logic              wr_grant_r,  wr_grant_s;
  logic              wr_done_r,   wr_done_s;
  logic              rd_grant_r,  rd_grant_s;
  logic              rd_valid_r,  rd_valid_s;
  logic              rd_done_r,   rd_done_s;
  logic              mem_we_r,    mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r,  mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;

  // Arbitration and burst-end decode
  logic              wr_win_s;
  logic              rd_win_s;
  logic              last_beat_s;

  // Arbitration: a lone request wins; on a tie the requester not served last wins.
  always_comb begin
    wr_win_s    = 1'b0;
    rd_win_s    = 1'b0;
    last_beat_s = (offset_r == (len_r - ADDR_ONE));
    if (bus.wr_req && (!bus.rd_req || (last_r == LAST_RD))) begin
      wr_win_s = 1'b1;
    end else if (bus.rd_req) begin
      rd_win_s = 1'b1;
    end else begin
      wr_win_s = 1'b0;
      rd_win_s = 1'b0;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // and registered, so every value below is what the pins show next cycle.
  always_comb begin
    state_s     = state_r;
    last_s      = last_r;
    base_s      = base_r;
    len_s       = len_r;
    offset_s    = offset_r;
    wr_grant_s  = 1'b0;
    wr_done_s   = 1'b0;
    rd_grant_s  = 1'b0;
    rd_valid_s  = 1'b0;
    rd_done_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;

    case (state_r)
      ST_IDLE: begin
        if (wr_win_s) begin
          base_s   = bus.wr_addr;
          len_s    = bus.wr_len;
          offset_s = ADDR_ZERO;
          last_s   = LAST_WR;
          // A zero-length burst skips straight to the tail: done only.
          if (bus.wr_len == ADDR_ZERO) begin
            state_s   = ST_W_TAIL;
            wr_done_s = 1'b1;
          end else begin
            state_s    = ST_WRITE;
            wr_grant_s = 1'b1;
          end
        end else if (rd_win_s) begin
          base_s     = bus.rd_addr;
          len_s      = bus.rd_len;
          offset_s   = ADDR_ZERO;
          last_s     = LAST_RD;
          // First read address goes out together with the grant.
          mem_addr_s = bus.rd_addr;
          if (bus.rd_len == ADDR_ZERO) begin
            state_s   = ST_R_TAIL;
            rd_done_s = 1'b1;
          end else begin
            state_s    = ST_READ;
            rd_grant_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WRITE: begin
        // The byte presented under grant this cycle is written next cycle.
        mem_we_s    = 1'b1;
        mem_addr_s  = base_r + offset_r;
        mem_wdata_s = bus.wr_data;
        offset_s    = offset_r + ADDR_ONE;
        if (last_beat_s) begin
          state_s   = ST_W_TAIL;
          wr_done_s = 1'b1;
        end else begin
          state_s    = ST_WRITE;
          wr_grant_s = 1'b1;
        end
      end

      ST_W_TAIL: begin
        state_s = ST_IDLE;
      end

      ST_READ: begin
        // Data for the address issued this cycle arrives next cycle.
        rd_valid_s = 1'b1;
        offset_s   = offset_r + ADDR_ONE;
        if (last_beat_s) begin
          state_s   = ST_R_TAIL;
          rd_done_s = 1'b1;
        end else begin
          state_s    = ST_READ;
          rd_grant_s = 1'b1;
          mem_addr_s = base_r + offset_r + ADDR_ONE;
        end
      end

      ST_R_TAIL: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, bookkeeping and output registers; reset aborts any burst silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      last_r      <= LAST_RD;
      base_r      <= ADDR_ZERO;
      len_r       <= ADDR_ZERO;
      offset_r    <= ADDR_ZERO;
      wr_grant_r  <= 1'b0;
      wr_done_r   <= 1'b0;
      rd_grant_r  <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_done_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= ADDR_ZERO;
      mem_wdata_r <= DATA_ZERO;
    end else begin
      state_r     <= state_s;
      last_r      <= last_s;
      base_r      <= base_s;
      len_r       <= len_s;
      offset_r    <= offset_s;
      wr_grant_r  <= wr_grant_s;
      wr_done_r   <= wr_done_s;
      rd_grant_r  <= rd_grant_s;
      rd_valid_r  <= rd_valid_s;
      rd_done_r   <= rd_done_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign bus.wr_grant  = wr_grant_r;
  assign bus.wr_done   = wr_done_r;
  assign bus.rd_grant  = rd_grant_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_done   = rd_done_r;
  assign bus.rd_data   = bus.mem_rdata;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

  pit_mem_arbiter_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .wr_grant (wr_grant_r),
    .wr_done  (wr_done_r),
    .rd_grant (rd_grant_r),
    .rd_valid (rd_valid_r),
    .rd_done  (rd_done_r),
    .mem_we   (mem_we_r)
  );

endmodule

// File: tb/tb_pit_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_pit_mem_arbiter
//
// Table-driven bench for pit_mem_arbiter. Each record describes one clock
// cycle: the inputs driven during that cycle and the outputs expected during
// it. Outputs are checked at the falling edge, then the record's inputs are
// applied. A behavioural 1024 x 8 memory with one-cycle read latency sits on
// the memory bus. A hand-written sequence covers asynchronous reset mid-burst.
// ----------------------------------------------------------------------------
module tb_pit_mem_arbiter;

  localparam logic [5:0] F0 = 6'b000000;
  // Flag order: {wr_grant, wr_done, rd_grant, rd_valid, rd_done, mem_we}
  localparam logic [5:0] WG = 6'b100000;
  localparam logic [5:0] WD = 6'b010000;
  localparam logic [5:0] RG = 6'b001000;
  localparam logic [5:0] RV = 6'b000100;
  localparam logic [5:0] RD = 6'b000010;
  localparam logic [5:0] WE = 6'b000001;

  typedef struct {
    string      name;
    logic       rst;
    logic       wr_req;
    logic [9:0] wr_addr;
    logic [9:0] wr_len;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [9:0] rd_addr;
    logic [9:0] rd_len;
    logic [5:0] fl;     // expected flags
    int         ea;     // expected mem_addr, -1 = don't care
    int         ew;     // expected mem_wdata, -1 = don't care
    int         er;     // expected rd_data, -1 = don't care
  } vec_t;

  logic clk;
  logic reset;
  logic [7:0] mem [1024];

  pit_mem_arbiter_if #(.ADDR_W(10), .DATA_W(8)) bus ();

  pit_mem_arbiter #(.ADDR_W(10), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, registered read; reset reloads the image.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h100] <= 8'h11;
      mem[10'h101] <= 8'h22;
      mem[10'h102] <= 8'h33;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Current input values used when building records
  logic       c_rst;
  logic       c_wr_req;
  logic [9:0] c_wr_addr;
  logic [9:0] c_wr_len;
  logic [7:0] c_wr_data;
  logic       c_rd_req;
  logic [9:0] c_rd_addr;
  logic [9:0] c_rd_len;

  int n_vec;
  int n_bad;
  vec_t vq[$];

  function automatic vec_t mk(string nm, logic [5:0] fl, int ea, int ew, int er);
    vec_t v;
    v.name = nm;       v.rst = c_rst;
    v.wr_req = c_wr_req; v.wr_addr = c_wr_addr; v.wr_len = c_wr_len; v.wr_data = c_wr_data;
    v.rd_req = c_rd_req; v.rd_addr = c_rd_addr; v.rd_len = c_rd_len;
    v.fl = fl; v.ea = ea; v.ew = ew; v.er = er;
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    reset       = v.rst;
    bus.wr_req  = v.wr_req;
    bus.wr_addr = v.wr_addr;
    bus.wr_len  = v.wr_len;
    bus.wr_data = v.wr_data;
    bus.rd_req  = v.rd_req;
    bus.rd_addr = v.rd_addr;
    bus.rd_len  = v.rd_len;
  endtask

  task automatic drive_cur();
    drive_vec(mk("drv", F0, -1, -1, -1));
  endtask

  task automatic check_vec(input vec_t v);
    logic [5:0] got;
    logic       bad;
    got = {bus.wr_grant, bus.wr_done, bus.rd_grant, bus.rd_valid, bus.rd_done, bus.mem_we};
    bad = (got !== v.fl);
    if (v.ea >= 0 && bus.mem_addr !== v.ea[9:0]) bad = 1'b1;
    if (v.ew >= 0 && bus.mem_wdata !== v.ew[7:0]) bad = 1'b1;
    if (v.er >= 0 && bus.rd_data !== v.er[7:0]) bad = 1'b1;
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: flags{wg,wd,rg,rv,rd,we} got %b want %b; mem_addr got %0d want %0d; mem_wdata got %h want %0d; rd_data got %h want %0d",
               v.name, got, v.fl, bus.mem_addr, v.ea, bus.mem_wdata, v.ew, bus.rd_data, v.er);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    c_rst = 1'b1; c_wr_req = 1'b0; c_wr_addr = 10'd0; c_wr_len = 10'd0; c_wr_data = 8'h00;
    c_rd_req = 1'b0; c_rd_addr = 10'd0; c_rd_len = 10'd0;
    drive_cur();

    // ---- reset state
    vq.push_back(mk("rst_hold", F0, 0, 0, -1));
    c_rst = 1'b0;
    vq.push_back(mk("rst_rel", F0, 0, 0, -1));

    // ---- write burst 0x010, len 4, A0..A3
    c_wr_req = 1'b1; c_wr_addr = 10'h010; c_wr_len = 10'd4;
    vq.push_back(mk("wr_arb", F0, -1, -1, -1));
    c_wr_req = 1'b0; c_wr_data = 8'hA0;
    vq.push_back(mk("wr_g0", WG, -1, -1, -1));
    c_wr_data = 8'hA1;
    vq.push_back(mk("wr_b0", WG | WE, 16'h010, 8'hA0, -1));
    c_wr_data = 8'hA2;
    vq.push_back(mk("wr_b1", WG | WE, 16'h011, 8'hA1, -1));
    c_wr_data = 8'hA3;
    vq.push_back(mk("wr_b2", WG | WE, 16'h012, 8'hA2, -1));
    c_wr_data = 8'h00;
    vq.push_back(mk("wr_b3_done", WD | WE, 16'h013, 8'hA3, -1));
    vq.push_back(mk("wr_idle", F0, -1, -1, -1));

    // ---- read burst 0x100, len 3
    c_rd_req = 1'b1; c_rd_addr = 10'h100; c_rd_len = 10'd3;
    vq.push_back(mk("rd_arb", F0, -1, -1, -1));
    c_rd_req = 1'b0;
    vq.push_back(mk("rd_g0", RG, 16'h100, -1, -1));
    vq.push_back(mk("rd_b0", RG | RV, 16'h101, -1, 8'h11));
    vq.push_back(mk("rd_b1", RG | RV, 16'h102, -1, 8'h22));
    vq.push_back(mk("rd_b2_done", RV | RD, -1, -1, 8'h33));
    vq.push_back(mk("rd_idle", F0, -1, -1, -1));

    // ---- simultaneous requests after reset, then alternation
    c_rst = 1'b1;
    vq.push_back(mk("sim_rst", F0, -1, -1, -1));
    c_rst = 1'b0;
    c_wr_req = 1'b1; c_wr_addr = 10'h020; c_wr_len = 10'd2;
    c_rd_req = 1'b1; c_rd_addr = 10'h100; c_rd_len = 10'd2;
    vq.push_back(mk("sim_arb1", F0, 0, 0, -1));
    c_wr_req = 1'b0; c_wr_data = 8'hB0;
    vq.push_back(mk("sim_wr_g0", WG, -1, -1, -1));
    c_wr_data = 8'hB1;
    vq.push_back(mk("sim_wr_b0", WG | WE, 16'h020, 8'hB0, -1));
    c_wr_data = 8'h00;
    vq.push_back(mk("sim_wr_done", WD | WE, 16'h021, 8'hB1, -1));
    c_wr_req = 1'b1; c_wr_addr = 10'h030; c_wr_len = 10'd2;
    vq.push_back(mk("sim_arb2", F0, -1, -1, -1));
    c_rd_req = 1'b0;
    vq.push_back(mk("sim_rd_g0", RG, 16'h100, -1, -1));
    vq.push_back(mk("sim_rd_b0", RG | RV, 16'h101, -1, 8'h11));
    vq.push_back(mk("sim_rd_done", RV | RD, -1, -1, 8'h22));
    c_rd_req = 1'b1;
    vq.push_back(mk("sim_arb3", F0, -1, -1, -1));
    c_wr_req = 1'b0; c_wr_data = 8'hC0;
    vq.push_back(mk("sim_wr2_g0", WG, -1, -1, -1));
    c_wr_data = 8'hC1;
    vq.push_back(mk("sim_wr2_b0", WG | WE, 16'h030, 8'hC0, -1));
    c_rd_req = 1'b0; c_wr_data = 8'h00;
    vq.push_back(mk("sim_wr2_done", WD | WE, 16'h031, 8'hC1, -1));
    vq.push_back(mk("sim_idle", F0, -1, -1, -1));

    // ---- wrap-around write 1022, len 4
    c_wr_req = 1'b1; c_wr_addr = 10'd1022; c_wr_len = 10'd4;
    vq.push_back(mk("wrap_arb", F0, -1, -1, -1));
    c_wr_req = 1'b0; c_wr_data = 8'hD0;
    vq.push_back(mk("wrap_g0", WG, -1, -1, -1));
    c_wr_data = 8'hD1;
    vq.push_back(mk("wrap_1022", WG | WE, 1022, 8'hD0, -1));
    c_wr_data = 8'hD2;
    vq.push_back(mk("wrap_1023", WG | WE, 1023, 8'hD1, -1));
    c_wr_data = 8'hD3;
    vq.push_back(mk("wrap_0", WG | WE, 0, 8'hD2, -1));
    c_wr_data = 8'h00;
    vq.push_back(mk("wrap_1_done", WD | WE, 1, 8'hD3, -1));
    vq.push_back(mk("wrap_idle", F0, -1, -1, -1));

    // ---- zero-length write and read
    c_wr_req = 1'b1; c_wr_addr = 10'h050; c_wr_len = 10'd0;
    vq.push_back(mk("z_wr_arb", F0, -1, -1, -1));
    c_wr_req = 1'b0;
    vq.push_back(mk("z_wr_done", WD, -1, -1, -1));
    vq.push_back(mk("z_wr_idle", F0, -1, -1, -1));
    c_rd_req = 1'b1; c_rd_addr = 10'h100; c_rd_len = 10'd0;
    vq.push_back(mk("z_rd_arb", F0, -1, -1, -1));
    c_rd_req = 1'b0;
    vq.push_back(mk("z_rd_done", RD, -1, -1, -1));
    vq.push_back(mk("z_rd_idle", F0, -1, -1, -1));

    // ---- apply the table
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      check_vec(vq[i]);
      drive_vec(vq[i]);
    end

    // ---- reset in the third byte of a len-8 write
    @(negedge clk);
    check_vec(mk("mb_idle", F0, -1, -1, -1));
    c_wr_req = 1'b1; c_wr_addr = 10'h040; c_wr_len = 10'd8;
    drive_cur();
    @(negedge clk);
    check_vec(mk("mb_g0", WG, -1, -1, -1));
    c_wr_req = 1'b0; c_wr_data = 8'hE0;
    drive_cur();
    @(negedge clk);
    check_vec(mk("mb_b0", WG | WE, 16'h040, 8'hE0, -1));
    c_wr_data = 8'hE1;
    drive_cur();
    @(negedge clk);
    check_vec(mk("mb_b1", WG | WE, 16'h041, 8'hE1, -1));
    c_wr_data = 8'hE2;
    drive_cur();
    #2;
    c_rst = 1'b1;
    drive_cur();
    #1;
    check_vec(mk("mb_async_clear", F0, 0, 0, -1));
    @(negedge clk);
    check_vec(mk("mb_rst_hold", F0, 0, 0, -1));
    c_rst = 1'b0;
    c_wr_req = 1'b1; c_wr_addr = 10'h060; c_wr_len = 10'd2; c_wr_data = 8'h00;
    c_rd_req = 1'b1; c_rd_addr = 10'h100; c_rd_len = 10'd2;
    drive_cur();
    @(negedge clk);
    check_vec(mk("mb_wr_first", WG, -1, -1, -1));
    c_wr_req = 1'b0; c_wr_data = 8'hF0;
    drive_cur();
    @(negedge clk);
    check_vec(mk("mb_wr_b0", WG | WE, 16'h060, 8'hF0, -1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pit_mem_arbiter.md
# pit_mem_arbiter

Arbiter and burst sequencer for the single-port PIT packet memory (1024 x 8). It shares the memory between two requesters: the interest-in writer, which stores an incoming packet into its PIT slot, and the data-out reader, which streams a stored packet back out on a PIT hit. It sits between the PIT control logic and the memory, owns every memory address, write-enable and write-data cycle, and guarantees that bursts never interleave.

## Interface
- ADDR_W, 10, memory address width and burst-length width
- DATA_W, 8, memory data width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- wr_req  in  1  writer burst request (level)
- wr_addr  in  ADDR_W  writer base address, sampled at arbitration
- wr_len  in  ADDR_W  writer burst length in bytes, sampled at arbitration
- wr_data  in  DATA_W  writer byte; must be valid in every cycle where wr_grant=1
- wr_grant  out  1  writer owns the memory; one byte is consumed per high cycle
- wr_done  out  1  one-cycle pulse marking the end of the writer burst
- rd_req  in  1  reader burst request (level)
- rd_addr  in  ADDR_W  reader base address, sampled at arbitration
- rd_len  in  ADDR_W  reader burst length in bytes, sampled at arbitration
- rd_grant  out  1  reader owns the memory; one address is issued per high cycle
- rd_data  out  DATA_W  combinational copy of mem_rdata
- rd_valid  out  1  rd_data is a burst byte this cycle
- rd_done  out  1  one-cycle pulse marking the end of the reader burst
- mem_addr  out  ADDR_W  registered memory address
- mem_we  out  1  registered memory write enable
- mem_wdata  out  DATA_W  registered memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr

## Operation
- States:
  - IDLE, WRITE and W_TAIL form the writer path.
  - READ and R_TAIL form the reader path.
- A register `last` records which requester was served most recently. Its reset value is READ, so the writer wins first.
- IDLE behaviour:
  - If only one request is high, that requester wins.
  - If both are high, the requester not equal to `last` wins.
  - On a win, the winner's addr and len are latched into base and len, offset is cleared, `last` is updated, and the FSM goes to WRITE or READ.
  - If neither request is high, the FSM stays in IDLE.
- WRITE state, on each cycle:
  - wr_grant=1.
  - At the next edge: mem_we<=1, mem_addr<=base+offset, mem_wdata<=wr_data, offset<=offset+1.
  - When offset==len-1, the FSM goes to W_TAIL.
- W_TAIL state:
  - mem_we=1 for the final byte and wr_done=1.
  - mem_we is cleared at the next edge and the FSM goes to IDLE.
- READ state, on each cycle:
  - rd_grant=1, and mem_addr=base+offset (registered, loaded when entering READ).
  - rd_valid follows one cycle later.
  - When offset==len-1, the FSM goes to R_TAIL.
- R_TAIL state:
  - The final rd_valid=1 and rd_done=1.
  - The FSM goes to IDLE.
- len=0 bursts:
  - The FSM goes directly to the TAIL state.
  - done pulses with no grant, no mem_we and no rd_valid.
- Address arithmetic is ADDR_W bits, modulo 2^ADDR_W. A burst starting at 1020 with len 8 covers 1020..1023 then 0..3. Maximum len is 1023.
- Request protocol:
  - A requester holds req until its grant or done appears.
  - A requester must deassert req in its done cycle.
  - A req still high when the FSM returns to IDLE is treated as a new burst.
- A losing request is held pending; it is not dropped.
- mem_we is 0 in every state except the cycles listed for WRITE and W_TAIL.
- Reset, asynchronous and including mid-burst:
  - state=IDLE, last=READ, offset=0.
  - All outputs are 0: wr_grant, wr_done, rd_grant, rd_valid, rd_done, mem_we, mem_addr, mem_wdata.
  - The aborted burst produces no done pulse.

## Timing
- Let A be the IDLE cycle in which req is sampled high, and G=A+1.
- Writer burst:
  - wr_grant is high in cycles G..G+len-1.
  - mem_we is high in cycles G+1..G+len.
  - wr_done is high in cycle G+len.
- Reader burst:
  - rd_grant is high in cycles G..G+len-1, and mem_addr=base+k in cycle G+k.
  - rd_valid is high in cycles G+1..G+len.
  - rd_done is high in cycle G+len.
- IDLE is reached at G+len+1. The earliest next grant is G+len+2, giving one idle bubble between bursts.
- A requester raising req while the other's burst is in progress waits until the IDLE cycle. Worst-case wait is len+2 cycles.
- All outputs are registered except rd_data.

## Test plan
- Write burst: wr_req, wr_addr=0x010, wr_len=4, data A0..A3 -> mem_we is high for 4 cycles at addresses 0x010..0x013 with data A0..A3; wr_done pulses once, in the cycle of the last mem_we.
- Read burst: preload 0x100..0x102=11,22,33, then rd_req with len=3 -> rd_valid is high for 3 cycles with rd_data 11,22,33; rd_done is coincident with the last byte; mem_we stays 0.
- Simultaneous requests after reset: both requests high, len=2 each -> writer is served first, then reader after one IDLE cycle. Repeat with both still requesting -> the order alternates: reader-last leads to writer, writer-last leads to reader.
- Wrap-around: write at wr_addr=1022, len=4 -> mem_addr sequence is 1022, 1023, 0, 1.
- Zero length: wr_len=0 -> wr_done pulses at G; wr_grant and mem_we are never asserted.
- Reset mid-burst: assert reset during the third byte of a len=8 write -> all outputs are 0 immediately and no wr_done appears. After release, with rd_req and wr_req both high, the writer is granted first.
